// File: rtl/sum_accumulator.sv
// sum_accumulator: clocked reduction stage behind the 2-bit adder.
// Accepts COUNT unsigned sums over a valid/ready handshake and adds them
// into a saturating ACC_W-bit register. The window total is then held on
// the output handshake until downstream takes it.
module sum_accumulator #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  // With COUNT=1 the beat counter still needs one bit, which simply stays at 0.
  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               accept;
  logic [ACC_W:0]     sum_wide;

  // The addition carries one spare bit. If that bit is set, the sum has
  // passed the largest value the accumulator can hold, so the result is
  // clamped to all ones.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
    if (s[ACC_W]) return {ACC_W{1'b1}};
    return s[ACC_W-1:0];
  endfunction

  assign in_ready  = (state_q == ACCUM) && !reset;
  assign accept    = in_valid && in_ready;
  assign sum_wide  = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};

  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

  // Next-state logic. In both states, clear is checked before accept and
  // before the output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          acc_d = sat_acc(sum_wide);
          ovf_d = ovf_q | sum_wide[ACC_W];
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (clear || out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State registers. Reset takes priority over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed testbench for sum_accumulator. It builds three instances:
// the default one (IN_W=3, ACC_W=8, COUNT=4), a narrow one (ACC_W=4) that
// reaches saturation, and a COUNT=1 instance. All three share the same inputs.
module tb_sum_accumulator;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_sum = '0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_sum;
  logic       s_in_ready, s_out_valid, s_out_ovf;
  logic [3:0] s_out_sum;
  logic       c_in_ready, c_out_valid, c_out_ovf;
  logic [7:0] c_out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sum_accumulator #(.IN_W(3), .ACC_W(8), .COUNT(4)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  sum_accumulator #(.IN_W(3), .ACC_W(4), .COUNT(4)) dut_sat (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_sum(in_sum),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_ovf(s_out_ovf)
  );

  sum_accumulator #(.IN_W(3), .ACC_W(8), .COUNT(1)) dut_c1 (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_sum(in_sum),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf)
  );

  // Advance one rising edge, then settle so the outputs can be sampled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [2:0] v);
    in_valid = 1'b1;
    in_sum   = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_sum = 3'd5;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 8'd0) begin errors++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(3'd3);
    checks++; if (c_out_valid !== 1'b1 || c_out_sum !== 8'd3 || c_in_ready !== 1'b0) begin
      errors++; $display("FAIL count1_done got v=%b s=%0d r=%b exp v=1 s=3 r=0", c_out_valid, c_out_sum, c_in_ready); end
    checks++; if (out_valid !== 1'b0 || out_sum !== 8'd3) begin
      errors++; $display("FAIL basic_partial got v=%b s=%0d exp v=0 s=3", out_valid, out_sum); end
    beat(3'd5);
    beat(3'd7);
    beat(3'd1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_sum !== 8'd16) begin errors++; $display("FAIL basic_out_sum got=%0d exp=16", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_out_ovf got=%b exp=0", out_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got=%b exp=0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_restart got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
    checks++; if (out_sum !== 8'd0) begin errors++; $display("FAIL basic_acc_restart got=%0d exp=0", out_sum); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    beat(3'd1); beat(3'd2); beat(3'd3); beat(3'd0);
    checks++; if (out_valid !== 1'b1 || out_sum !== 8'd6) begin
      errors++; $display("FAIL bp_window got v=%b s=%0d exp v=1 s=6", out_valid, out_sum); end
    in_valid = 1'b1; in_sum = 3'd7;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
      checks++; if (out_sum !== 8'd6 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b s=%0d exp v=1 s=6", i, out_valid, out_sum); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    beat(3'd2); beat(3'd2); beat(3'd2); beat(3'd2);
    checks++; if (out_valid !== 1'b1 || out_sum !== 8'd8) begin
      errors++; $display("FAIL bp_next_window got v=%b s=%0d exp v=1 s=8", out_valid, out_sum); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    beat(3'd7);
    checks++; if (s_out_sum !== 4'd7 || s_out_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_step1 got s=%0d o=%b exp s=7 o=0", s_out_sum, s_out_ovf); end
    beat(3'd7);
    checks++; if (s_out_sum !== 4'd14 || s_out_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_step2 got s=%0d o=%b exp s=14 o=0", s_out_sum, s_out_ovf); end
    beat(3'd7);
    checks++; if (s_out_sum !== 4'd15 || s_out_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_step3 got s=%0d o=%b exp s=15 o=1", s_out_sum, s_out_ovf); end
    beat(3'd7);
    checks++; if (s_out_valid !== 1'b1 || s_out_sum !== 4'd15 || s_out_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_result got v=%b s=%0d o=%b exp v=1 s=15 o=1", s_out_valid, s_out_sum, s_out_ovf); end
    checks++; if (out_sum !== 8'd28 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL wide_no_sat got s=%0d o=%b exp s=28 o=0", out_sum, out_ovf); end
    out_ready = 1'b1;
    tick();
    beat(3'd1); beat(3'd1); beat(3'd1); beat(3'd1);
    checks++; if (s_out_valid !== 1'b1 || s_out_sum !== 4'd4 || s_out_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_next_window got v=%b s=%0d o=%b exp v=1 s=4 o=0", s_out_valid, s_out_sum, s_out_ovf); end
    tick();
  endtask

  task automatic test_sparse();
    logic [6:0] vpat;
    logic [2:0] spat [7];
    do_reset();
    out_ready = 1'b0;
    vpat = 7'b1101001;  // bit i drives cycle i
    spat = '{3'd1, 3'd7, 3'd7, 3'd2, 3'd7, 3'd3, 3'd4};
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i];
      in_sum   = spat[i];
      tick();
      if (i == 5) begin
        checks++; if (out_valid !== 1'b0 || out_sum !== 8'd6) begin
          errors++; $display("FAIL sparse_partial got v=%b s=%0d exp v=0 s=6", out_valid, out_sum); end
      end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== 8'd10) begin
      errors++; $display("FAIL sparse_result got v=%b s=%0d exp v=1 s=10", out_valid, out_sum); end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b0;
    beat(3'd5); beat(3'd5);
    clear = 1'b1; in_valid = 1'b1; in_sum = 3'd6;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (out_sum !== 8'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_accum got s=%0d v=%b exp s=0 v=0", out_sum, out_valid); end
    beat(3'd1); beat(3'd2); beat(3'd3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_count_restart got v=%b exp=0", out_valid); end
    beat(3'd4);
    checks++; if (out_valid !== 1'b1 || out_sum !== 8'd10) begin
      errors++; $display("FAIL clear_next_window got v=%b s=%0d exp v=1 s=10", out_valid, out_sum); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL clear_done got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_in_done();
    do_reset();
    out_ready = 1'b0;
    beat(3'd3); beat(3'd5); beat(3'd7); beat(3'd1);
    checks++; if (out_valid !== 1'b1 || out_sum !== 8'd16) begin
      errors++; $display("FAIL rdone_window got v=%b s=%0d exp v=1 s=16", out_valid, out_sum); end
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL rdone_cleared got v=%b s=%0d o=%b exp v=0 s=0 o=0", out_valid, out_sum, out_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rdone_in_ready_held got=%b exp=0", in_ready); end
    reset = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rdone_in_ready_after got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_sparse();
    test_clear();
    test_reset_in_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
